// File: rtl/pc_return_unit.sv
// Program counter with a hardware return-address stack for CALL/RET and interrupt vectoring.
// Interrupt logic (INTR, INT_SET, INT_CLR, IE, INT_ACK) is present only when PC_INTR_EN is defined.
module pc_return_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                STK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(10'h3FF)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] D_IN,
    input  logic              PC_LD,
    input  logic              PC_INC,
    input  logic              CALL,
    input  logic              RET,
    input  logic              RETIE,
    input  logic              INTR,
    input  logic              INT_SET,
    input  logic              INT_CLR,
    output logic [ADDR_W-1:0] PC_COUNT,
    output logic              STK_EMPTY,
    output logic              STK_FULL,
    output logic              STK_ERR,
    output logic              IE,
    output logic              INT_ACK
);
    localparam int CNT_W = $clog2(STK_DEPTH + 1);
    localparam int PTR_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stk_q [STK_DEPTH];
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              ret_any;
    logic              push;
    logic              take;

    assign ret_any = RET | RETIE;
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign wr_ptr  = PTR_W'(cnt_q);
    assign rd_ptr  = PTR_W'(cnt_q - CNT_W'(1));
    assign stk_top = stk_q[rd_ptr];

    // A call and an interrupt take share the push path; only the new PC differs.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (ret_any) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                pc_d  = stk_top;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (CALL || take) begin
            pc_d = CALL ? D_IN : INT_VEC;
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                push  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (PC_LD) begin
            pc_d = D_IN;
        end else if (PC_INC) begin
            pc_d = pc_inc;
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(STK_DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Stack storage is not reset; entries above the count are never read.
    always_ff @(posedge CLK) begin
        if (push) begin
            stk_q[wr_ptr] <= pc_inc;
        end
    end

`ifdef PC_INTR_EN
    logic inc_wins;
    logic ie_q, ie_d;
    logic ack_q, ack_d;

    assign inc_wins = PC_INC & ~ret_any & ~CALL & ~PC_LD;
    assign take     = inc_wins & INTR & ie_q;
    assign ack_d    = take;

    always_comb begin
        ie_d = ie_q;
        if (INT_CLR) begin
            ie_d = 1'b0;
        end else if (INT_SET) begin
            ie_d = 1'b1;
        end
        if (take) begin
            ie_d = 1'b0;
        end
        if (RETIE) begin
            ie_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ie_q  <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            ack_q <= ack_d;
        end
    end

    assign IE      = ie_q;
    assign INT_ACK = ack_q;
`else
    logic unused_intr;
    assign unused_intr = INTR ^ INT_SET ^ INT_CLR;
    assign take        = 1'b0;
    assign IE          = 1'b0;
    assign INT_ACK     = 1'b0;
`endif

    assign PC_COUNT  = pc_q;
    assign STK_EMPTY = empty_q;
    assign STK_FULL  = full_q;
    assign STK_ERR   = err_q;
endmodule

// File: tb/tb_pc_return_unit.sv
// Directed bench for pc_return_unit: each step queues its expected outputs, then checks them after the edge.
module tb_pc_return_unit;
    logic       clk = 1'b0;
    logic       rst_n, pc_ld, pc_inc, call, ret, retie, intr, int_set, int_clr;
    logic [9:0] d_in;
    logic [9:0] pc_count;
    logic       stk_empty, stk_full, stk_err, ie, int_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [9:0] pc;
        logic       empty;
        logic       full;
        logic       err;
        logic       ie;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];

    pc_return_unit dut (
        .CLK(clk), .RST_N(rst_n), .D_IN(d_in), .PC_LD(pc_ld), .PC_INC(pc_inc),
        .CALL(call), .RET(ret), .RETIE(retie), .INTR(intr), .INT_SET(int_set),
        .INT_CLR(int_clr), .PC_COUNT(pc_count), .STK_EMPTY(stk_empty),
        .STK_FULL(stk_full), .STK_ERR(stk_err), .IE(ie), .INT_ACK(int_ack)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst_n = 1'b1; pc_ld = 1'b0; pc_inc = 1'b0; call = 1'b0; ret = 1'b0;
        retie = 1'b0; intr = 1'b0; int_set = 1'b0; int_clr = 1'b0; d_in = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Inputs are already driven by the caller; apply one edge and compare against the queued entry.
    task automatic step(input string tag, input logic [9:0] epc, input logic ee, input logic ef,
                        input logic eerr, input logic eie, input logic eack);
        exp_t e;
        exp_t got;
        e.tag = tag; e.pc = epc; e.empty = ee; e.full = ef; e.err = eerr; e.ie = eie; e.ack = eack;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        idle();
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = sb_q.pop_front();
            chk({got.tag, ".pc"},    32'(pc_count),  32'(got.pc));
            chk({got.tag, ".empty"}, 32'(stk_empty), 32'(got.empty));
            chk({got.tag, ".full"},  32'(stk_full),  32'(got.full));
            chk({got.tag, ".err"},   32'(stk_err),   32'(got.err));
            chk({got.tag, ".ie"},    32'(ie),        32'(got.ie));
            chk({got.tag, ".ack"},   32'(int_ack),   32'(got.ack));
            $display("step %-12s pc=%03h empty=%0b full=%0b err=%0b ie=%0b ack=%0b",
                     got.tag, pc_count, stk_empty, stk_full, stk_err, ie, int_ack);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step("reset", 10'h000, 1, 0, 0, 0, 0);
        // reset, increment, reset overriding increment
        pc_inc = 1; step("inc1", 10'h001, 1, 0, 0, 0, 0);
        pc_inc = 1; step("inc2", 10'h002, 1, 0, 0, 0, 0);
        pc_inc = 1; step("inc3", 10'h003, 1, 0, 0, 0, 0);
        rst_n = 0; pc_inc = 1; step("rst_inc", 10'h000, 1, 0, 0, 0, 0);
        // load and wrap
        pc_ld = 1; d_in = 10'h3FE; step("ld_3fe", 10'h3FE, 1, 0, 0, 0, 0);
        pc_inc = 1; step("inc_3ff", 10'h3FF, 1, 0, 0, 0, 0);
        pc_inc = 1; step("wrap", 10'h000, 1, 0, 0, 0, 0);
        // call / return / priority
        pc_ld = 1; d_in = 10'h010; step("ld_010", 10'h010, 1, 0, 0, 0, 0);
        call = 1; d_in = 10'h100; step("call_100", 10'h100, 0, 0, 0, 0, 0);
        ret = 1; step("ret_011", 10'h011, 1, 0, 0, 0, 0);
        call = 1; d_in = 10'h100; step("call_b", 10'h100, 0, 0, 0, 0, 0);
        ret = 1; call = 1; pc_ld = 1; pc_inc = 1; d_in = 10'h300;
        step("ret_wins", 10'h012, 1, 0, 0, 0, 0);
        // overflow and underflow
        call = 1; d_in = 10'h040; step("call1", 10'h040, 0, 0, 0, 0, 0);
        call = 1; d_in = 10'h080; step("call2", 10'h080, 0, 0, 0, 0, 0);
        call = 1; d_in = 10'h0C0; step("call3", 10'h0C0, 0, 0, 0, 0, 0);
        call = 1; d_in = 10'h100; step("call4_full", 10'h100, 0, 1, 0, 0, 0);
        call = 1; d_in = 10'h200; step("call5_ovf", 10'h200, 0, 1, 1, 0, 0);
        ret = 1; step("ret1", 10'h0C1, 0, 0, 1, 0, 0);
        ret = 1; step("ret2", 10'h081, 0, 0, 1, 0, 0);
        ret = 1; step("ret3", 10'h041, 0, 0, 1, 0, 0);
        ret = 1; step("ret4", 10'h013, 1, 0, 1, 0, 0);
        ret = 1; step("ret5_udf", 10'h013, 1, 0, 1, 0, 0);
        pc_inc = 1; step("err_sticky", 10'h014, 1, 0, 1, 0, 0);
        rst_n = 0; call = 1; d_in = 10'h155; step("rst_call", 10'h000, 1, 0, 0, 0, 0);
`ifdef PC_INTR_EN
        pc_ld = 1; d_in = 10'h020; int_set = 1; step("ld_020_ie", 10'h020, 1, 0, 0, 1, 0);
        intr = 1; pc_inc = 1; step("int_take", 10'h3FF, 0, 0, 0, 0, 1);
        step("ack_drop", 10'h3FF, 0, 0, 0, 0, 0);
        retie = 1; step("retie", 10'h021, 1, 0, 0, 1, 0);
        intr = 1; pc_ld = 1; d_in = 10'h050; step("defer_ld", 10'h050, 1, 0, 0, 1, 0);
        intr = 1; pc_inc = 1; step("defer_take", 10'h3FF, 0, 0, 0, 0, 1);
        ret = 1; step("ret_051", 10'h051, 1, 0, 0, 0, 0);
        intr = 1; pc_inc = 1; step("ie_off_inc", 10'h052, 1, 0, 0, 0, 0);
        int_set = 1; step("set", 10'h052, 1, 0, 0, 1, 0);
        int_set = 1; int_clr = 1; step("clr_wins", 10'h052, 1, 0, 0, 0, 0);
        retie = 1; int_clr = 1; step("retie_udf", 10'h052, 1, 0, 1, 1, 0);
`else
        pc_ld = 1; d_in = 10'h020; int_set = 1; step("ld_020_ie", 10'h020, 1, 0, 0, 0, 0);
        intr = 1; pc_inc = 1; step("no_take", 10'h021, 1, 0, 0, 0, 0);
        intr = 1; pc_ld = 1; d_in = 10'h050; step("defer_ld", 10'h050, 1, 0, 0, 0, 0);
        intr = 1; pc_inc = 1; step("no_take2", 10'h051, 1, 0, 0, 0, 0);
        retie = 1; int_set = 1; step("retie_udf", 10'h051, 1, 0, 1, 0, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
